// File: rtl/seg7_pkg.sv
// Shared constants and types for the 7-segment scan driver.
// Segment vectors are {g,f,e,d,c,b,a}, active-high.
package seg7_pkg;

    localparam logic [6:0] SEG_0    = 7'b0111111;
    localparam logic [6:0] SEG_1    = 7'b0000110;
    localparam logic [6:0] SEG_2    = 7'b1011011;
    localparam logic [6:0] SEG_3    = 7'b1001111;
    localparam logic [6:0] SEG_4    = 7'b1100110;
    localparam logic [6:0] SEG_5    = 7'b1101101;
    localparam logic [6:0] SEG_6    = 7'b1111101;
    localparam logic [6:0] SEG_7    = 7'b0000111;
    localparam logic [6:0] SEG_8    = 7'b1111111;
    localparam logic [6:0] SEG_9    = 7'b1101111;
    localparam logic [6:0] SEG_DASH = 7'b1000000;
    localparam logic [6:0] SEG_OFF  = 7'b0000000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } scan_state_t;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to 7-segment decoder; codes 10-15 render as a dash.
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 7-segment scanner with blank guard slots and per-digit blink.
//   state    | meaning
//   ST_IDLE  | display dark, waiting for ENABLE
//   ST_BLANK | all anodes off, DIGIT_SEL presented, BCD captured on last cycle
//   ST_SHOW  | selected anode lit with the captured digit
module seg_scan_driver
    import seg7_pkg::*;
#(
    parameter int                    NUM_DIGITS   = 6,
    parameter int                    REFRESH_DIV  = 1000,
    parameter int                    BLANK_CYCLES = 16,
    parameter logic [NUM_DIGITS-1:0] DP_MASK      = 6'b010100,
    parameter bit                    ACTIVE_LOW   = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  ENABLE,
    input  logic [NUM_DIGITS-1:0] BLINK_MASK,
    input  logic                  BLINK_PHASE,
    output logic [2:0]            DIGIT_SEL,
    input  logic [3:0]            DIGIT_BCD,
    output logic [6:0]            SEG,
    output logic                  DP,
    output logic [NUM_DIGITS-1:0] AN,
    output logic                  FRAME_DONE
);

    localparam int CNT_MAX  = (BLANK_CYCLES > REFRESH_DIV) ? BLANK_CYCLES : REFRESH_DIV;
    localparam int CNT_W    = ($clog2(CNT_MAX) < 1) ? 1 : $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SHOW_LOAD  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [2:0]       LAST_DIGIT = 3'(NUM_DIGITS - 1);

    scan_state_t           state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [2:0]            digit_q, digit_d;
    logic [3:0]            bcd_q, bcd_d;

    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic                  fd_q, fd_d;

    logic [6:0]            seg_dec;
    logic [NUM_DIGITS-1:0] onehot;
    logic                  lit;

    bcd_to_seg7 u_dec (
        .bcd_i (bcd_d),
        .seg_o (seg_dec)
    );

    // Output registers hold pin polarity so the reset value is already "inactive".
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            digit_q <= '0;
            bcd_q   <= '0;
            an_q    <= {NUM_DIGITS{ACTIVE_LOW}};
            seg_q   <= {7{ACTIVE_LOW}};
            dp_q    <= ACTIVE_LOW;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            digit_q <= digit_d;
            bcd_q   <= bcd_d;
            an_q    <= an_d ^ {NUM_DIGITS{ACTIVE_LOW}};
            seg_q   <= seg_d ^ {7{ACTIVE_LOW}};
            dp_q    <= dp_d ^ ACTIVE_LOW;
            fd_q    <= fd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        digit_d = digit_q;
        bcd_d   = bcd_q;
        if (!ENABLE) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            digit_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_BLANK;
                    cnt_d   = BLANK_LOAD;
                    digit_d = '0;
                end
                ST_BLANK: begin
                    if (cnt_q == '0) begin
                        state_d = ST_SHOW;
                        cnt_d   = SHOW_LOAD;
                        bcd_d   = DIGIT_BCD;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_SHOW: begin
                    if (cnt_q == '0) begin
                        state_d = ST_BLANK;
                        cnt_d   = BLANK_LOAD;
                        digit_d = (digit_q == LAST_DIGIT) ? 3'd0 : digit_q + 3'd1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    digit_d = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they line up with it once registered.
    always_comb begin
        onehot = NUM_DIGITS'(1) << digit_d;
        lit    = (state_d == ST_SHOW) && !((|(BLINK_MASK & onehot)) && !BLINK_PHASE);
        an_d   = lit ? onehot : '0;
        seg_d  = lit ? seg_dec : SEG_OFF;
        dp_d   = lit && (|(DP_MASK & onehot));
        fd_d   = (state_d == ST_SHOW) && (cnt_d == '0) && (digit_d == LAST_DIGIT);
    end

    assign DIGIT_SEL  = digit_q;
    assign AN         = an_q;
    assign SEG        = seg_q;
    assign DP         = dp_q;
    assign FRAME_DONE = fd_q;

endmodule
